// File: rtl/escape_ring_engine_if.sv
// Point/result handshake bundle for the escape-time ring engine.
// master = point producer / result consumer, slave = engine.
interface escape_ring_engine_if #(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 16,
  parameter int TAG_W  = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [WIDTH-1:0]  in_re;
  logic signed [WIDTH-1:0]  in_im;
  logic [TAG_W-1:0]         in_tag;
  logic                     in_julia;
  logic signed [WIDTH-1:0]  julia_re;
  logic signed [WIDTH-1:0]  julia_im;
  logic [ITER_W-1:0]        max_iter;
  logic                     out_valid;
  logic                     out_ready;
  logic [TAG_W-1:0]         out_tag;
  logic [ITER_W-1:0]        out_iter;
  logic                     out_escaped;

  modport master (
    output in_valid, in_re, in_im, in_tag, in_julia, julia_re, julia_im, max_iter, out_ready,
    input  in_ready, out_valid, out_tag, out_iter, out_escaped
  );

  modport slave (
    input  in_valid, in_re, in_im, in_tag, in_julia, julia_re, julia_im, max_iter, out_ready,
    output in_ready, out_valid, out_tag, out_iter, out_escaped
  );
endinterface

// File: rtl/escape_ring_engine.sv
// Four-slot circulating escape-time engine: z <- z^2 + c for up to four tagged
// points, retiring out of order through a single held result register.
module escape_ring_engine #(
  parameter int WIDTH  = 32,
  parameter int FRAC   = 28,
  parameter int ITER_W = 16,
  parameter int TAG_W  = 8
) (
  input logic               aclk,
  input logic               aresetn,
  escape_ring_engine_if.slave bus
);

  typedef logic signed [WIDTH-1:0]   word_t;
  typedef logic signed [WIDTH:0]     wide_t;
  typedef logic signed [2*WIDTH-1:0] prod_t;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              escaped;
    logic              ovf;
    word_t             zr;
    word_t             zi;
    word_t             cr;
    word_t             ci;
    logic [ITER_W-1:0] count;
    logic [ITER_W-1:0] limit;
    logic [TAG_W-1:0]  tag;
  } slot_t;

  localparam prod_t SAT_HI = prod_t'({1'b0, {(WIDTH-1){1'b1}}});
  localparam prod_t SAT_LO = ~SAT_HI;
  localparam wide_t FOUR   = {{(WIDTH-FRAC-2){1'b0}}, 1'b1, {(FRAC+2){1'b0}}};

  function automatic word_t sat_val(input prod_t v);
    if (v > SAT_HI)      return word_t'(SAT_HI);
    else if (v < SAT_LO) return word_t'(SAT_LO);
    else                 return word_t'(v);
  endfunction

  function automatic logic is_sat(input prod_t v);
    return (v > SAT_HI) || (v < SAT_LO);
  endfunction

  slot_t st [4];
  word_t aa_q, bb_q, ab_q;
  wide_t mag_q, d_q, t_q, mag3_q;
  word_t zr_n_q, zi_n_q;

  prod_t p_aa, p_bb, p_ab, sum_r, sum_i;
  wide_t mag_c, d_c, t_c;
  slot_t s1_next, nxt, cur;
  logic  esc_now, lim_now, finishing, retire, accept;

  always_comb begin
    p_aa = (prod_t'(st[0].zr) * prod_t'(st[0].zr)) >>> FRAC;
    p_bb = (prod_t'(st[0].zi) * prod_t'(st[0].zi)) >>> FRAC;
    p_ab = (prod_t'(st[0].zr) * prod_t'(st[0].zi)) >>> FRAC;
    s1_next     = st[0];
    s1_next.ovf = is_sat(p_aa) | is_sat(p_bb) | is_sat(p_ab);
    mag_c = wide_t'(aa_q) + wide_t'(bb_q);
    d_c   = wide_t'(aa_q) - wide_t'(bb_q);
    t_c   = wide_t'(ab_q) <<< 1;
    sum_r = prod_t'(d_q) + prod_t'(st[2].cr);
    sum_i = prod_t'(t_q) + prod_t'(st[2].ci);
  end

  // S3: a point escaping or hitting its limit this pass may retire in the same
  // cycle; a done point that cannot retire keeps circulating frozen.
  always_comb begin
    cur       = st[3];
    esc_now   = cur.valid & ~cur.done & ((mag3_q > FOUR) | cur.ovf);
    lim_now   = cur.valid & ~cur.done & ~esc_now & (cur.count == cur.limit);
    finishing = cur.valid & (cur.done | esc_now | lim_now);
    retire    = finishing & (~bus.out_valid | bus.out_ready);
    bus.in_ready = aresetn & (~cur.valid | retire);
    accept    = bus.in_valid & bus.in_ready;

    nxt = cur;
    if (cur.valid & ~cur.done & ~esc_now & ~lim_now) begin
      nxt.count = cur.count + 1'b1;
      nxt.zr    = zr_n_q;
      nxt.zi    = zi_n_q;
    end
    if (esc_now) begin
      nxt.done    = 1'b1;
      nxt.escaped = 1'b1;
    end
    if (lim_now) begin
      nxt.done    = 1'b1;
      nxt.escaped = 1'b0;
    end
    if (retire) nxt.valid = 1'b0;
    if (accept) begin
      nxt       = '0;
      nxt.valid = 1'b1;
      nxt.tag   = bus.in_tag;
      nxt.limit = bus.max_iter;
      nxt.zr    = bus.in_julia ? bus.in_re    : '0;
      nxt.zi    = bus.in_julia ? bus.in_im    : '0;
      nxt.cr    = bus.in_julia ? bus.julia_re : bus.in_re;
      nxt.ci    = bus.in_julia ? bus.julia_im : bus.in_im;
    end
  end

  // Arithmetic side registers travel in lockstep with the slot they belong to;
  // they are meaningless for empty slots, so they need no reset.
  always_ff @(posedge aclk) begin
    aa_q   <= sat_val(p_aa);
    bb_q   <= sat_val(p_bb);
    ab_q   <= sat_val(p_ab);
    mag_q  <= mag_c;
    d_q    <= d_c;
    t_q    <= t_c;
    mag3_q <= mag_q;
    zr_n_q <= sat_val(sum_r);
    zi_n_q <= sat_val(sum_i);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < 4; i++) st[i] <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_tag     <= '0;
      bus.out_iter    <= '0;
      bus.out_escaped <= 1'b0;
    end else begin
      st[0] <= nxt;
      st[1] <= s1_next;
      st[2] <= st[1];
      st[3] <= st[2];
      if (retire) begin
        bus.out_valid   <= 1'b1;
        bus.out_tag     <= cur.tag;
        bus.out_iter    <= cur.count;
        bus.out_escaped <= cur.done ? cur.escaped : esc_now;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_escape_ring_engine.sv
// Scoreboard bench for escape_ring_engine: directed scenarios plus random
// points, checked against an arithmetic escape-time reference model.
module tb_escape_ring_engine;
  localparam int WIDTH  = 32;
  localparam int FRAC   = 28;
  localparam int ITER_W = 16;
  localparam int TAG_W  = 8;
  localparam longint HI   = (longint'(1) << (WIDTH-1)) - 1;
  localparam longint LO   = -(longint'(1) << (WIDTH-1));
  localparam longint FOUR = longint'(4) << FRAC;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  escape_ring_engine_if #(.WIDTH(WIDTH), .ITER_W(ITER_W), .TAG_W(TAG_W)) bus ();

  escape_ring_engine #(.WIDTH(WIDTH), .FRAC(FRAC), .ITER_W(ITER_W), .TAG_W(TAG_W)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .bus(bus)
  );

  typedef struct {
    logic [TAG_W-1:0] tag;
    int               iter;
    bit               esc;
    int               acc;
  } exp_t;

  exp_t             sb[$];
  logic [TAG_W-1:0] ret_tags[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  lat_check = 1'b0;
  bit  rand_ready = 1'b0;
  int  last_tag, last_iter, last_esc, last_lat;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  function automatic longint satv(input longint v);
    return (v > HI) ? HI : ((v < LO) ? LO : v);
  endfunction

  function automatic longint fx(input real r);
    return longint'(r * (2.0 ** FRAC));
  endfunction

  // Escape-time iteration straight from the fixed-point arithmetic rules.
  function automatic void ref_model(input longint z0r, input longint z0i, input longint cr,
                                    input longint ci, input int limit,
                                    output int iter, output bit esc);
    longint zr, zi, aa, bb, ab, pa, pb, pab;
    bit ovf;
    zr = z0r; zi = z0i; iter = limit; esc = 1'b0;
    for (int n = 0; n <= limit; n++) begin
      pa  = (zr * zr) >>> FRAC;
      pb  = (zi * zi) >>> FRAC;
      pab = (zr * zi) >>> FRAC;
      ovf = (pa != satv(pa)) || (pb != satv(pb)) || (pab != satv(pab));
      aa = satv(pa); bb = satv(pb); ab = satv(pab);
      if ((aa + bb > FOUR) || ovf) begin
        iter = n; esc = 1'b1;
        return;
      end
      if (n == limit) begin
        iter = n; esc = 1'b0;
        return;
      end
      zr = satv(aa - bb + cr);
      zi = satv(2 * ab + ci);
    end
  endfunction

  task automatic applyStimulus(input longint re, input longint im, input int tag, input bit julia,
                               input longint jre, input longint jim, input int maxit,
                               output int stall);
    int it;
    bit es;
    bit acc;
    if (julia) ref_model(re, im, jre, jim, maxit, it, es);
    else       ref_model(0, 0, re, im, maxit, it, es);
    bus.in_re    = WIDTH'(re);
    bus.in_im    = WIDTH'(im);
    bus.in_tag   = TAG_W'(tag);
    bus.in_julia = julia;
    bus.julia_re = WIDTH'(jre);
    bus.julia_im = WIDTH'(jim);
    bus.max_iter = ITER_W'(maxit);
    bus.in_valid = 1'b1;
    stall = 0;
    acc = 1'b0;
    while (!acc && stall <= 1000) begin
      @(negedge aclk);
      if (bus.in_ready) begin
        acc = 1'b1;
        sb.push_back('{tag: TAG_W'(tag), iter: it, esc: es, acc: cyc + 1});
      end
      @(posedge aclk); #1;
      if (!acc) stall++;
    end
    bus.in_valid = 1'b0;
    if (!acc) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge aclk); #1;
      n++;
    end
    checkOutput("drain_pending", sb.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk); #1;
    end
  endtask

  initial forever begin
    @(posedge aclk); #1;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: every accepted result is matched by tag against the scoreboard.
  initial begin : monitor
    int idx;
    forever begin
      @(negedge aclk);
      if (aresetn && bus.out_valid && bus.out_ready) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (idx < 0 && sb[i].tag == bus.out_tag) idx = i;
        if (idx < 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result tag=%0d iter=%0d required=none", bus.out_tag, bus.out_iter);
        end else begin
          last_tag  = int'(bus.out_tag);
          last_iter = int'(bus.out_iter);
          last_esc  = int'(bus.out_escaped);
          last_lat  = cyc - sb[idx].acc;
          checkOutput($sformatf("iter_tag%0d", bus.out_tag), bus.out_iter, sb[idx].iter);
          checkOutput($sformatf("esc_tag%0d", bus.out_tag), bus.out_escaped, sb[idx].esc);
          if (lat_check)
            checkOutput($sformatf("latency_tag%0d", bus.out_tag), last_lat, 4 * (sb[idx].iter + 1));
          ret_tags.push_back(bus.out_tag);
          sb.delete(idx);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int st;
    int changes;
    bit seen;
    logic [TAG_W-1:0] h_tag;
    logic [ITER_W-1:0] h_iter;
    logic h_esc;
    longint re, im, jre, jim;
    bit jul;

    bus.in_valid = 1'b0; bus.in_re = '0; bus.in_im = '0; bus.in_tag = '0;
    bus.in_julia = 1'b0; bus.julia_re = '0; bus.julia_im = '0; bus.max_iter = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_out_tag", bus.out_tag, 0);
    checkOutput("rst_out_iter", bus.out_iter, 0);
    checkOutput("rst_out_escaped", bus.out_escaped, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    checkOutput("post_rst_in_ready", bus.in_ready, 1);
    @(posedge aclk); #1;

    lat_check = 1'b1;
    applyStimulus(fx(2.0), 0, 1, 1'b0, 0, 0, 10, st);
    wait_drain(200);
    checkOutput("c2_iter", last_iter, 2);
    checkOutput("c2_esc", last_esc, 1);
    checkOutput("c2_latency", last_lat, 12);

    applyStimulus(0, 0, 2, 1'b0, 0, 0, 10, st);
    wait_drain(200);
    checkOutput("c0_iter", last_iter, 10);
    checkOutput("c0_esc", last_esc, 0);
    checkOutput("c0_latency", last_lat, 44);

    applyStimulus(fx(1.5), 0, 3, 1'b1, 0, 0, 50, st);
    wait_drain(400);
    checkOutput("julia_iter", last_iter, 1);
    checkOutput("julia_esc", last_esc, 1);

    applyStimulus(fx(2.5), 0, 4, 1'b1, 0, 0, 0, st);
    wait_drain(100);
    checkOutput("max0_iter", last_iter, 0);
    checkOutput("max0_esc", last_esc, 1);
    checkOutput("max0_latency", last_lat, 4);

    ret_tags.delete();
    applyStimulus(fx(2.0), 0, 0, 1'b0, 0, 0, 8, st);  checkOutput("b2b_stall0", st, 0);
    applyStimulus(0, 0, 1, 1'b0, 0, 0, 8, st);        checkOutput("b2b_stall1", st, 0);
    applyStimulus(fx(3.0), 0, 2, 1'b0, 0, 0, 8, st);  checkOutput("b2b_stall2", st, 0);
    applyStimulus(fx(-2.0), 0, 3, 1'b0, 0, 0, 8, st); checkOutput("b2b_stall3", st, 0);
    wait_drain(300);
    checkOutput("b2b_count", ret_tags.size(), 4);
    if (ret_tags.size() == 4) begin
      checkOutput("b2b_order0", ret_tags[0], 2);
      checkOutput("b2b_order1", ret_tags[1], 0);
      checkOutput("b2b_order2", ret_tags[2], 1);
      checkOutput("b2b_order3", ret_tags[3], 3);
    end

    lat_check = 1'b0;
    bus.out_ready = 1'b0;
    ret_tags.delete();
    applyStimulus(fx(2.0), 0, 0, 1'b0, 0, 0, 8, st);
    applyStimulus(0, 0, 1, 1'b0, 0, 0, 8, st);
    applyStimulus(fx(3.0), 0, 2, 1'b0, 0, 0, 8, st);
    applyStimulus(fx(-2.0), 0, 3, 1'b0, 0, 0, 8, st);
    seen = 1'b0;
    changes = 0;
    h_tag = '0; h_iter = '0; h_esc = 1'b0;
    repeat (60) begin
      @(negedge aclk);
      if (seen) begin
        if (!bus.out_valid || bus.out_tag != h_tag || bus.out_iter != h_iter || bus.out_escaped != h_esc)
          changes++;
      end else if (bus.out_valid) begin
        seen = 1'b1;
        h_tag = bus.out_tag; h_iter = bus.out_iter; h_esc = bus.out_escaped;
      end
    end
    checkOutput("bp_held_seen", seen, 1);
    checkOutput("bp_held_tag", h_tag, 2);
    checkOutput("bp_held_changes", changes, 0);
    @(posedge aclk); #1;
    bus.out_ready = 1'b1;
    wait_drain(300);
    checkOutput("bp_retired", ret_tags.size(), 4);

    lat_check = 1'b1;
    applyStimulus(0, 0, 10, 1'b0, 0, 0, 30, st);
    applyStimulus(0, 0, 11, 1'b0, 0, 0, 30, st);
    applyStimulus(0, 0, 12, 1'b0, 0, 0, 30, st);
    idle(3);
    aresetn = 1'b0;
    sb.delete();
    ret_tags.delete();
    @(negedge aclk);
    checkOutput("midrst_in_ready_low", bus.in_ready, 0);
    @(negedge aclk);
    checkOutput("midrst_out_valid", bus.out_valid, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    checkOutput("midrst_in_ready", bus.in_ready, 1);
    @(posedge aclk); #1;
    applyStimulus(fx(2.0), 0, 20, 1'b0, 0, 0, 10, st);
    idle(200);
    wait_drain(100);
    checkOutput("midrst_retired", ret_tags.size(), 1);
    checkOutput("midrst_tag", last_tag, 20);
    checkOutput("midrst_iter", last_iter, 2);

    lat_check = 1'b0;
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      re  = longint'($urandom_range(0, 1342177280)) - 64'sd671088640;
      im  = longint'($urandom_range(0, 1342177280)) - 64'sd671088640;
      jre = longint'($urandom_range(0, 536870912)) - 64'sd268435456;
      jim = longint'($urandom_range(0, 536870912)) - 64'sd268435456;
      jul = 1'($urandom_range(0, 1));
      applyStimulus(re, im, 100 + i, jul, jre, jim, int'($urandom_range(0, 20)), st);
      idle(int'($urandom_range(0, 3)));
    end
    wait_drain(3000);
    rand_ready = 1'b0;
    @(posedge aclk); #1;
    bus.out_ready = 1'b1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
